// File: rtl/rr_lock_arbiter.sv
// N-way round-robin arbiter with lockable, registered one-hot grant and tenure counter.
// Define ARB_HOLD_TIMEOUT_EN to break a lock after MAX_HOLD cycles when others are waiting.
module rr_lock_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned W_CNT    = 8,
  parameter int unsigned MAX_HOLD = 255,
  localparam int unsigned W_IDX   = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             hold,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [W_IDX-1:0] gnt_idx,
  output logic [W_CNT-1:0] hold_cnt
);

  localparam int unsigned W_SUM = W_IDX + 1;

  if (N_REQ < 2) begin : g_bad_n_req
    $error("rr_lock_arbiter: N_REQ must be at least 2");
  end
  if (64'(MAX_HOLD) >= (64'd1 << W_CNT)) begin : g_bad_max_hold
    $error("rr_lock_arbiter: MAX_HOLD must fit in W_CNT bits");
  end

  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             valid_q, valid_d;
  logic [W_IDX-1:0] idx_q, idx_d;
  logic [W_IDX-1:0] ptr_q, ptr_d;
  logic [W_CNT-1:0] cnt_q, cnt_d;

  logic             found;
  logic [W_IDX-1:0] win;
  logic [W_SUM-1:0] cand;
  logic [W_SUM-1:0] win_inc;
  logic             locked;

  // Rotating priority scan: first requester at or after ptr wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr_q} + W_SUM'(i);
      if (cand >= W_SUM'(N_REQ)) cand = cand - W_SUM'(N_REQ);
      if (!found && req[cand[W_IDX-1:0]]) begin
        found = 1'b1;
        win   = cand[W_IDX-1:0];
      end
    end
  end

  always_comb begin
    locked = valid_q & hold & (|(gnt_q & req));
`ifdef ARB_HOLD_TIMEOUT_EN
    // Forced rotation only when someone else is actually waiting.
    if ((cnt_q == W_CNT'(MAX_HOLD)) && (|(req & ~gnt_q))) locked = 1'b0;
`endif
  end

  always_comb begin
    win_inc = {1'b0, win} + W_SUM'(1);
    if (win_inc == W_SUM'(N_REQ)) win_inc = '0;

    gnt_d   = gnt_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    if (!locked) begin
      if (found) begin
        gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << win;
        valid_d = 1'b1;
        idx_d   = win;
        ptr_d   = win_inc[W_IDX-1:0];
      end else begin
        gnt_d   = '0;
        valid_d = 1'b0;
        idx_d   = '0;
      end
    end

    // Tenure restarts on a new owner; an unlocked re-grant of the same owner keeps counting.
    if (!valid_d || (gnt_d != gnt_q)) begin
      cnt_d = '0;
    end else if (cnt_q != {W_CNT{1'b1}}) begin
      cnt_d = cnt_q + W_CNT'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = valid_q;
  assign gnt_idx   = idx_q;
  assign hold_cnt  = cnt_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Scoreboard bench for rr_lock_arbiter: driver queues expected outputs, monitor checks them.
// Covers the default build and the ARB_HOLD_TIMEOUT_EN build (MAX_HOLD=8).
module tb_rr_lock_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       hold;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic [7:0] hold_cnt;

  int tests;
  int fails;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic [7:0] cnt;
    string      name;
  } exp_t;

  exp_t sb[$];

  rr_lock_arbiter #(
    .N_REQ   (4),
    .W_CNT   (8),
    .MAX_HOLD(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .hold     (hold),
    .gnt      (gnt),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx),
    .hold_cnt (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: the DUT presents a new registered result after every edge.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if (gnt !== e.gnt || gnt_valid !== (|e.gnt) || gnt_idx !== e.idx || hold_cnt !== e.cnt) begin
        fails++;
        $display("FAIL %s: got gnt=%b valid=%b idx=%0d cnt=%0d, want gnt=%b valid=%b idx=%0d cnt=%0d",
                 e.name, gnt, gnt_valid, gnt_idx, hold_cnt, e.gnt, |e.gnt, e.idx, e.cnt);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      tests++;
      if (!$onehot0(gnt)) begin
        fails++;
        $display("FAIL onehot: got gnt=%b, want one-hot or zero", gnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic [3:0] r, input logic h, input logic [3:0] eg,
                      input logic [1:0] ei, input logic [7:0] ec, input string nm);
    req  = r;
    hold = h;
    sb.push_back('{eg, ei, ec, nm});
    @(negedge clk);
  endtask

  task automatic check_idle(input string nm);
    tests++;
    if (gnt !== 4'b0 || gnt_valid !== 1'b0 || gnt_idx !== 2'd0 || hold_cnt !== 8'd0) begin
      fails++;
      $display("FAIL %s: got gnt=%b valid=%b idx=%0d cnt=%0d, want all zero",
               nm, gnt, gnt_valid, gnt_idx, hold_cnt);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    req   = 4'b1111;
    hold  = 1'b0;

    // 1: reset with all requesting
    #12;
    check_idle("reset_held");
    @(negedge clk);
    check_idle("reset_held2");
    rst_n = 1'b1;
    step(4'b1111, 1'b0, 4'b0001, 2'd0, 8'd0, "first_after_reset");

    // 2: free rotation
    step(4'b1111, 1'b0, 4'b0010, 2'd1, 8'd0, "rot1");
    step(4'b1111, 1'b0, 4'b0100, 2'd2, 8'd0, "rot2");
    step(4'b1111, 1'b0, 4'b1000, 2'd3, 8'd0, "rot3");
    step(4'b1111, 1'b0, 4'b0001, 2'd0, 8'd0, "rot_wrap");

    // 3: lock owner 0 for 20 cycles, then handoff to 2
    step(4'b0000, 1'b0, 4'b0000, 2'd0, 8'd0, "idle");
    step(4'b0001, 1'b0, 4'b0001, 2'd0, 8'd0, "grant0");
    for (int i = 1; i < 20; i++) step(4'b0101, 1'b1, 4'b0001, 2'd0, 8'(i), "lock0");
    step(4'b0101, 1'b0, 4'b0100, 2'd2, 8'd0, "handoff2");

    // 4: owner 1 locked, drops request while hold stays high
    step(4'b0000, 1'b0, 4'b0000, 2'd0, 8'd0, "idle2");
    step(4'b0010, 1'b0, 4'b0010, 2'd1, 8'd0, "grant1");
    step(4'b1010, 1'b1, 4'b0010, 2'd1, 8'd1, "lock1a");
    step(4'b1010, 1'b1, 4'b0010, 2'd1, 8'd2, "lock1b");
    step(4'b1000, 1'b1, 4'b1000, 2'd3, 8'd0, "release1");
    step(4'b0000, 1'b1, 4'b0000, 2'd0, 8'd0, "all_drop");

    // 5: lone requester regranted each edge, counter saturates
    step(4'b0100, 1'b0, 4'b0100, 2'd2, 8'd0, "solo2");
    for (int i = 1; i < 300; i++)
      step(4'b0100, 1'b0, 4'b0100, 2'd2, (i > 255) ? 8'd255 : 8'(i), "sat");
    step(4'b1100, 1'b0, 4'b1000, 2'd3, 8'd0, "after_sat");

    // 6: contention under lock (timeout build rotates after MAX_HOLD+1 cycles)
    step(4'b0000, 1'b0, 4'b0000, 2'd0, 8'd0, "idle3");
    step(4'b0011, 1'b1, 4'b0001, 2'd0, 8'd0, "tlock_grant");
    for (int i = 1; i <= 8; i++) step(4'b0011, 1'b1, 4'b0001, 2'd0, 8'(i), "tlock");
`ifdef ARB_HOLD_TIMEOUT_EN
    step(4'b0011, 1'b1, 4'b0010, 2'd1, 8'd0, "timeout_rotate");
`else
    for (int i = 9; i <= 12; i++) step(4'b0011, 1'b1, 4'b0001, 2'd0, 8'(i), "no_timeout");
`endif

    // Lone locked owner: lock persists in both builds
    step(4'b0000, 1'b0, 4'b0000, 2'd0, 8'd0, "idle4");
    step(4'b0001, 1'b1, 4'b0001, 2'd0, 8'd0, "solo_lock");
    for (int i = 1; i <= 12; i++) step(4'b0001, 1'b1, 4'b0001, 2'd0, 8'(i), "solo_persist");

    // Async reset mid-tenure: outputs drop without a clock edge, ptr back to 0
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1111, 1'b0, 4'b0001, 2'd0, 8'd0, "ptr_reset");

    repeat (3) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
